// File: rtl/psum_ofifo.sv
// Output FIFO for the systolic array's south edge: one circular buffer per column,
// popped as an aligned row once every column holds data.

module psum_col_fifo #(
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_i,
    input  logic [psum_bw-1:0] din_i,
    input  logic               pop_i,
    output logic [psum_bw-1:0] head_o,
    output logic               nonempty_o,
    output logic               full_o
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [psum_bw-1:0] mem_q [depth];
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               wr_acc, pop_acc;

    assign full_o     = (cnt_q == CW'(depth));
    assign nonempty_o = (cnt_q != '0);
    // Fullness is judged on the count at the start of the cycle, so a
    // same-cycle pop never makes room for a write to a full column.
    assign wr_acc     = wr_i && !full_o;
    assign pop_acc    = pop_i && nonempty_o;
    assign head_o     = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_acc)  wptr_d = wptr_q + AW'(1);
        if (pop_acc) rptr_d = rptr_q + AW'(1);
        case ({wr_acc, pop_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem_q[wptr_q] <= din_i;
    end
endmodule

module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_valid,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);
    logic [col-1:0][psum_bw-1:0] head;
    logic [col-1:0][psum_bw-1:0] out_q;
    logic [col-1:0]              nonempty, full;
    logic                        pop, drop;
    logic                        out_valid_q, overflow_q;

    for (genvar c = 0; c < col; c++) begin : g_col
        psum_col_fifo #(.psum_bw(psum_bw), .depth(depth)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .wr_i       (wr[c]),
            .din_i      (in[c*psum_bw +: psum_bw]),
            .pop_i      (pop),
            .head_o     (head[c]),
            .nonempty_o (nonempty[c]),
            .full_o     (full[c])
        );
    end

    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;
    assign drop    = |(wr & full);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (pop) out_q <= head;
            out_valid_q <= pop;
            overflow_q  <= overflow_q | drop;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: expected rows queued at pop time, checked by a
// negedge monitor whenever out_valid is seen.

module tb_psum_ofifo;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 16;
    typedef logic [COL*BW-1:0] row_t;

    logic           clk = 1'b0;
    logic           reset;
    row_t           in;
    logic [COL-1:0] wr;
    logic           rd;
    row_t           out;
    logic           out_valid, o_valid, o_full, o_ready, overflow;

    int   tests = 0;
    int   fails = 0;
    row_t expq[$];
    row_t last_row;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .out_valid(out_valid), .o_valid(o_valid), .o_full(o_full),
        .o_ready(o_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input int base, input int step);
        row_t r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(base + step*c);
        return r;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkrow(input string name, input row_t act, input row_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued row.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out_valid: got out %h with no pop expected", out);
            end else begin
                row_t e;
                e = expq.pop_front();
                if (out !== e) begin
                    fails++;
                    $display("FAIL row: got %h expected %h", out, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr = '0; rd = 1'b0;
    endtask

    task automatic do_reset;
        idle(); reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic pop_expect(input row_t e);
        rd = 1'b1; wr = '0; expq.push_back(e); last_row = e;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in = '0; last_row = '0;
        do_reset();

        // Reset state
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_full", o_full, 1'b0);
        chk("rst_o_ready", o_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chkrow("rst_out", out, '0);

        // Skewed fill: column c written at cycle c with 100+c
        in = mk(100, 1);
        for (int c = 0; c < COL; c++) begin
            chk("skew_o_valid_low", o_valid, 1'b0);
            wr = COL'(1) << c;
            tick();
        end
        wr = '0;
        chk("skew_o_valid_high", o_valid, 1'b1);
        pop_expect(mk(100, 1));
        chk("skew_o_valid_after_pop", o_valid, 1'b0);
        tick();

        // Full / overflow on column 0
        for (int k = 0; k < DEP; k++) begin
            in = mk(k, 0); wr = 8'h01; tick();
        end
        wr = '0;
        chk("full_o_full", o_full, 1'b1);
        chk("full_o_ready", o_ready, 1'b0);
        chk("full_no_overflow_yet", overflow, 1'b0);
        chk("full_o_valid_low", o_valid, 1'b0);
        in = mk(99, 0); wr = 8'h01; tick(); wr = '0;
        chk("overflow_set", overflow, 1'b1);
        for (int k = 0; k < DEP; k++) begin
            in = mk(k, 0); in[BW-1:0] = 16'd77; wr = 8'hFE; tick();
        end
        wr = '0;
        chk("all_full_o_valid", o_valid, 1'b1);
        // Write to a full column alongside a pop must still be dropped
        in = mk(99, 0); wr = 8'h01; rd = 1'b1; expq.push_back(mk(0, 0));
        tick();
        for (int k = 1; k < DEP; k++) pop_expect(mk(k, 0));
        chk("drained_o_valid", o_valid, 1'b0);
        chk("overflow_sticky", overflow, 1'b1);
        do_reset();
        chk("overflow_cleared", overflow, 1'b0);

        // Pointer wrap at steady occupancy 3
        for (int k = 0; k < 3; k++) begin
            in = mk(k*8 + 1, 1); wr = '1; tick();
        end
        for (int k = 0; k < 40; k++) begin
            in = mk((k+3)*8 + 1, 1); wr = '1; rd = 1'b1;
            expq.push_back(mk(k*8 + 1, 1));
            tick();
        end
        idle();
        chk("wrap_not_full", o_full, 1'b0);
        pop_expect(mk(40*8 + 1, 1));
        pop_expect(mk(41*8 + 1, 1));
        chk("wrap_one_left", o_valid, 1'b1);
        pop_expect(mk(42*8 + 1, 1));
        chk("wrap_empty", o_valid, 1'b0);

        // Empty read: nothing comes out, out holds
        rd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("empty_out_valid", out_valid, 1'b0);
            chkrow("empty_out_hold", out, last_row);
        end
        rd = 1'b0;
        chk("empty_o_valid", o_valid, 1'b0);

        // Write + pop with a single entry: old head comes out
        in = mk(16'h0011, 0); wr = '1; tick();
        in = mk(16'h0022, 0); wr = '1; rd = 1'b1; expq.push_back(mk(16'h0011, 0));
        tick();
        idle();
        chk("wp1_o_valid", o_valid, 1'b1);
        pop_expect(mk(16'h0022, 0));
        chk("wp1_empty", o_valid, 1'b0);

        // Reset mid-stream discards stored rows
        for (int k = 0; k < 5; k++) begin
            in = mk(16'h0300 + k, 0); wr = '1; tick();
        end
        wr = '0;
        do_reset();
        chk("mid_rst_o_valid", o_valid, 1'b0);
        chkrow("mid_rst_out", out, '0);
        in = mk(16'h00AA, 0); wr = '1; tick(); wr = '0;
        pop_expect(mk(16'h00AA, 0));
        chk("mid_rst_empty", o_valid, 1'b0);

        tick(); tick();
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL missing_rows: got %0d rows outstanding expected 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/psum_ofifo.md
PSUM_OFIFO -- requirements
Module: psum_ofifo

Interface
REQ-001 Parameter col, default 8: number of array columns, one per-column FIFO each.
REQ-002 Parameter psum_bw, default 16: partial-sum width per column.
REQ-003 Parameter depth, default 16: entries per column FIFO; power of 2, at least 2.
REQ-004 Ports run on one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in  input  psum_bw*col  south-edge psums; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-008 wr  input  col  per-column write strobe (the array's valid vector); bit c pushes column c.
REQ-009 rd  input  1  request to pop one aligned row across all columns.
REQ-010 out  output  psum_bw*col  registered aligned row; same column packing as in.
REQ-011 out_valid  output  1  one-cycle pulse marking new data on out.
REQ-012 o_valid  output  1  every column FIFO non-empty; a row is poppable.
REQ-013 o_full  output  1  at least one column FIFO is full.
REQ-014 o_ready  output  1  no column FIFO is full (the inverse of o_full).
REQ-015 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-016 Each column has an independent circular buffer with a write pointer, a read pointer (log2(depth) bits, wrapping modulo depth) and an occupancy count (0..depth).
REQ-017 Write rule:
- If wr[c]=1 and count[c]<depth at the start of the cycle, in[c] is stored at wptr[c], wptr[c] increments and count[c] increments.
- A write is accepted, not dropped, only under that condition.
REQ-018 Write to full column: if wr[c]=1 and count[c]==depth, the write is dropped, no pointer moves and overflow is set.
- This holds even when a pop occurs in the same cycle.
REQ-019 o_valid, o_full and o_ready are combinational from the current counts.
REQ-020 Pop rule: if rd=1 and o_valid=1, every column pops one entry in the same cycle (rptr[c] increments, count[c] decrements).
- On that edge, out is loaded with the head entry of each column.
REQ-021 out_valid is 1 in the cycle after an accepted pop, otherwise 0.
- Read latency is one cycle: rd sampled at edge N gives out and out_valid visible after edge N.
REQ-022 If rd=1 and o_valid=0, the request is ignored: no pointer moves, out holds, out_valid=0, no error flag.
REQ-023 Simultaneous write and pop on a non-full column:
- Both take effect.
- count[c] is unchanged.
- The written data lands behind existing entries.
REQ-024 Simultaneous write and pop with count[c]==1 (the last entry): the popped data is the old head, never the word being written.
REQ-025 Columns fill at skewed times, because column c's strobe lags column c-1 by one or more cycles.
- No row is released until the slowest column has data.
- Column order within a row is preserved by pointer index.
REQ-026 out holds its last value until the next accepted pop.
REQ-027 Data passes through unmodified (no sign handling or arithmetic on psums).
REQ-028 Counts never exceed depth and never go below 0 under any input sequence.

Reset
REQ-029 While reset=1 at a rising edge, all of the following are cleared and wr and rd are ignored:
- pointers and counts go to 0;
- out goes to 0;
- out_valid and overflow go to 0.
REQ-030 After reset: o_valid=0, o_full=0, o_ready=1.
REQ-031 Reset asserted mid-operation discards all stored entries; the first post-reset pop returns only data written after reset.
REQ-032 Storage array contents need not be cleared; they are unobservable because counts are zero.

Verification
REQ-033 Skewed fill: col=8, wr bit c first asserts at cycle c with value 100+c, one write per column.
- o_valid rises only after column 7's write.
- rd then gives out columns = 100..107 and a single out_valid pulse.
REQ-034 Full/overflow: 16 writes of value k (k=0..15) to column 0 only.
- o_full=1 and o_ready=0.
- A 17th write of value 99 is dropped and overflow=1.
- Then fill the other columns and pop 16 times: column 0 reads 0..15 in order, and 99 never appears.
REQ-035 Pointer wrap: 40 interleaved write/pop cycles at steady occupancy 3 on all columns.
- Output order matches input order across the index-15-to-0 wrap.
- Count stays at 3.
REQ-036 Empty read: rd=1 for 5 cycles with all FIFOs empty gives out_valid=0, out unchanged and counts 0.
REQ-037 Write+pop at count 1: the head holds 0x0011, and the same cycle writes 0x0022 and pops.
- out=0x0011 in every column.
- The next pop gives 0x0022.
REQ-038 Reset mid-stream: reset with 5 entries per column.
- Afterwards o_valid=0 and out=0.
- Write 0x00AA in all columns and pop: out gives 0x00AA in all columns.
